// File: rtl/serial_pkg.sv
// Shared definitions for the serializer/deserializer stages: FSM state encoding
// and the counter-width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Word-side handshake plus serial-side outputs of the word serializer.
interface word_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_word;
  logic             i_valid;
  logic             o_ready;
  logic             o_dout;
  logic             o_dout_valid;
  logic             o_first;
  logic             o_last;
  logic             o_busy;

  modport slave (
    input  i_word, i_valid,
    output o_ready, o_dout, o_dout_valid, o_first, o_last, o_busy
  );

  modport master (
    output i_word, i_valid,
    input  o_ready, o_dout, o_dout_valid, o_first, o_last, o_busy
  );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, LSB-first
// bit stream out, with a one-word holding register for bubble-free streaming.
module word_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic               i_clk,
  input logic               i_rst_n,
  word_serializer_if.slave  bus
);

  localparam int            BW       = cnt_w(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [BW-1:0]    r_bit_cnt;

  logic             w_accept;
  logic             w_word_end;
  logic             w_gap_end;
  logic             w_slot;
  logic             w_load_hold;
  logic             w_load_byp;
  logic             w_load;
  logic             w_to_hold;
  logic [WIDTH-1:0] w_load_word;

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int            GW       = cnt_w(GAP_CYCLES);
      localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

      logic [GW-1:0] r_gap_cnt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_gap_cnt <= '0;
        end else if (r_state != GAP) begin
          r_gap_cnt <= '0;
        end else begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
        end
      end

      assign w_gap_end = (r_state == GAP) && (r_gap_cnt == GAP_LAST);
    end else begin : g_nogap
      assign w_gap_end = 1'b0;
    end
  endgenerate

  assign w_accept   = bus.i_valid && !r_hold_full;
  assign w_word_end = (r_state == SHIFT) && (r_bit_cnt == BIT_LAST);

  // A load slot opens whenever shreg is free for the next word at this edge.
  assign w_slot      = (r_state == IDLE) || (w_word_end && (GAP_CYCLES == 0)) || w_gap_end;
  assign w_load_hold = w_slot && r_hold_full;
  assign w_load_byp  = w_slot && !r_hold_full && w_accept;
  assign w_load      = w_load_hold || w_load_byp;
  assign w_load_word = r_hold_full ? r_hold : bus.i_word;
  assign w_to_hold   = w_accept && !w_slot;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_word_end) begin
          if (GAP_CYCLES > 0) w_state_nxt = GAP;
          else                w_state_nxt = w_load ? SHIFT : IDLE;
        end
      end
      GAP: begin
        if (w_gap_end) w_state_nxt = w_load ? SHIFT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_load) begin
        r_shreg   <= w_load_word;
        r_bit_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_shreg   <= r_shreg >> 1;
        r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + 1'b1;
      end

      if (w_load_hold) begin
        r_hold_full <= 1'b0;
      end else if (w_to_hold) begin
        r_hold      <= bus.i_word;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign bus.o_ready      = !r_hold_full;
  assign bus.o_dout_valid = (r_state == SHIFT);
  assign bus.o_dout       = (r_state == SHIFT) && r_shreg[0];
  assign bus.o_first      = (r_state == SHIFT) && (r_bit_cnt == '0);
  assign bus.o_last       = w_word_end;
  assign bus.o_busy       = (r_state != IDLE) || r_hold_full;

endmodule
